// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0]  X0_REG         = '0;
  localparam int unsigned MC_TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF      = 16;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module hazard_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Load-use / branch / multi-cycle hazard control for the five-stage core,
// with a timeout-guarded multi-cycle wait and saturating perf counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = MC_TIMEOUT_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_re,
  input  logic             branch_taken,
  input  logic             mc_start,
  input  logic             mc_done,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             bubble_sel,
  output logic             ifid_flush,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned TW      = $clog2(MC_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);
  localparam logic [TW-1:0] TO_LAST = TW'(MC_TIMEOUT - 1);

  hz_state_e     r_state;
  hz_state_e     w_next_state;
  logic [TW-1:0] r_to_cnt;
  logic          r_mc_timeout;
  logic          w_load_use;
  logic          w_mc_enter;
  logic          w_to_expire;
  logic          w_flush_inc;
  logic          w_cnt_clr;

  assign w_load_use = ex_mem_re && (ex_rd != X0_REG) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

  // A taken branch squashes the op in EX, so it must not enter the wait.
  assign w_mc_enter  = (r_state == RUN) && !branch_taken && mc_start && !mc_done;
  assign w_to_expire = (r_state == MC_WAIT) && !mc_done && (r_to_cnt == TO_LAST);
  assign w_flush_inc = (r_state == RUN) && branch_taken;
  assign w_cnt_clr   = !rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      RUN:     if (w_mc_enter) w_next_state = MC_WAIT;
      MC_WAIT: if (mc_done || w_to_expire) w_next_state = RUN;
      default: w_next_state = RUN;
    endcase
  end

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    bubble_sel = 1'b0;
    ifid_flush = 1'b0;
    unique case (r_state)
      RUN: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          bubble_sel = 1'b1;
        end else if (mc_start && !mc_done) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          idex_we = 1'b0;
        end else if (mc_start) begin
          pc_we = 1'b1;
        end else if (w_load_use) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          bubble_sel = 1'b1;
        end
      end
      MC_WAIT: begin
        if (!mc_done && !w_to_expire) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          idex_we = 1'b0;
        end
      end
      default: pc_we = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt     <= '0;
      r_mc_timeout <= 1'b0;
    end else begin
      r_mc_timeout <= w_to_expire;
      if (w_mc_enter) begin
        r_to_cnt <= TO_ONE;
      end else if ((r_state == MC_WAIT) && !mc_done && !w_to_expire) begin
        r_to_cnt <= r_to_cnt + TO_ONE;
      end
    end
  end

  assign mc_timeout = r_mc_timeout;

  hazard_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .inc   (!pc_we),
    .clr   (w_cnt_clr),
    .count (stall_count)
  );

  hazard_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .inc   (w_flush_inc),
    .clr   (w_cnt_clr),
    .count (flush_count)
  );

endmodule
